moore_non_overlap_101111: RTL and testbench
===========================================

# moore_non_overlap_101111

Single-input serial sequence detector: a Moore FSM that asserts `z` for one clock cycle after the bit pattern 1-0-1-1-1-1 has been received on `x`, one bit per clock. Detection is non-overlapping: after a match, the search restarts from scratch and no bits of the matched pattern are reused. It sits behind any synchronous one-bit serial source and drives a registered match flag to downstream logic.

## Interface
- No parameters. The pattern 101111 is fixed.
- `clk`  input  1  sole clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset (`rst`=0 resets immediately, independent of `clk`).
- `x`  input  1  serial data bit, sampled on each rising edge of `clk`.
- `z`  output  1  match flag; decoded from state only (Moore), glitch-free (registered or state-decoded).

## Operation
- States: S0 idle/no prefix, S1 "1", S2 "10", S3 "101", S4 "1011", S5 "10111", S6 "101111" detected.
- Transitions, written as (x=0 → next, x=1 → next):
  - S0: 0→S0, 1→S1
  - S1: 0→S2, 1→S1
  - S2: 0→S0, 1→S3
  - S3: 0→S2, 1→S4
  - S4: 0→S2, 1→S5
  - S5: 0→S2, 1→S6
  - S6: 0→S0, 1→S1 (non-overlap: behaves exactly like S0; no suffix of the match is retained)
- Failing bits fall back to the longest proper prefix of 101111 that is a suffix of the bits received since the last reset or match. This is why S3, S4 and S5 go to S2 on 0.
- `z` = 1 iff the state is S6; otherwise 0.
- Unused state encodings (3-bit binary or one-hot) return to S0 on the next edge with `z`=0.

## Timing
- Reset: state=S0 and `z`=0 immediately on `rst` falling, held while `rst`=0. The first sample is taken on the first rising edge after `rst` deasserts.
- Latency: the edge that samples the sixth pattern bit moves the FSM to S6. `z` rises right after that edge and stays high exactly one cycle.
- `z` can be high for at most one cycle in a row. The minimum spacing between two `z` pulses is 6 cycles.
- Reset asserted mid-pattern or during S6 aborts it: `z` drops at once, and the partial prefix is lost.
- `x` must meet setup/hold around the rising edge of `clk`. There is no handshake or enable: every edge consumes one bit.

## Structure
- Shared package `seq_det_pkg` holds:
  - state enum `det_state_t` (S0..S6) with its encoding width;
  - localparam `PATTERN` = 6'b101111, for documentation and bench reference.
- One module, with three parts: a state register (async active-low reset), next-state combinational logic, and output decode.
- No sub-module is needed.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `x` toggling → `z`=0 and state=S0 throughout. Assert `rst`=0 asynchronously while in S6 → `z` falls without waiting for a clock edge.
- Basic stream: feed 1,1,0,1,1,1,1,0,0,1,0,1,1,1,1,0,1,1,1,1 (one bit per cycle) → `z` pulses exactly twice, one cycle after bit 7 and one cycle after bit 15. The trailing 0,1,1,1,1 produces no pulse.
- Non-overlap: feed 1,0,1,1,1,1,0,1,1,1,1 → exactly one `z` pulse, after bit 6. An overlapping detector would also fire after bit 11; this one must not.
- Back-to-back: feed 101111101111 → two pulses, after bit 6 and after bit 12, with `z` low for the 5 cycles between them.
- Fallback: feed 1,0,1,0,1,1,1,1 → pulse after bit 8 (S3 on 0 goes to S2). Feed 1,0,1,1,1,0,1,1,1,1 → pulse after bit 10 (S5 on 0 goes to S2).
- Near-misses: all-zeros, all-ones and 1011101110 for 20 cycles → `z` never asserts.

Source files
------------

// File: rtl/moore_non_overlap_101111_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the 101111 serial sequence detector.
//   STATE_W     : width of the binary state encoding
//   det_state_t : detector states S0 (no prefix) .. S6 (full match)
//   PATTERN     : the fixed pattern, MSB received first
//   is_match    : decodes the match state
// ---------------------------------------------------------------------------
package seq_det_pkg;

    localparam int STATE_W = 3;

    // Sn means "the last n bits are the first n bits of PATTERN".
    typedef enum logic [STATE_W-1:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6
    } det_state_t;

    localparam logic [5:0] PATTERN = 6'b101111;

    // True only in the full-match state. Invalid encodings never match.
    function automatic logic is_match(input det_state_t st);
        return (st == S6) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/moore_non_overlap_101111_if.sv
// ---------------------------------------------------------------------------
// moore_non_overlap_101111_if
// Serial link between a one-bit source and the sequence detector.
//   x : serial data bit, one per clock (source -> detector)
//   z : one-cycle match flag      (detector -> consumer)
// Modports:
//   master : the serial source / observer side
//   slave  : the detector side
// ---------------------------------------------------------------------------
interface moore_non_overlap_101111_if;

    logic x;
    logic z;

    modport master (
        output x,
        input  z
    );

    modport slave (
        input  x,
        output z
    );

endinterface

// File: rtl/moore_non_overlap_101111.sv
// ---------------------------------------------------------------------------
// moore_non_overlap_101111
// Moore FSM that flags the serial pattern 1-0-1-1-1-1 on x. The flag z is
// high for exactly one cycle, starting right after the edge that samples the
// sixth pattern bit. Detection is non-overlapping: after a match the search
// restarts from nothing.
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous, active-low reset
//   bus : slave modport (x in, z out)
// ---------------------------------------------------------------------------
module moore_non_overlap_101111
    import seq_det_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    moore_non_overlap_101111_if.slave    bus
);

    det_state_t state_r;
    det_state_t next_state_s;
    logic       z_r;

    // State register and registered match flag. z_r is loaded from the
    // decode of the state being entered, so it is high exactly while
    // state_r holds S6 and is cleared asynchronously together with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S0;
            z_r     <= 1'b0;
        end else begin
            state_r <= next_state_s;
            z_r     <= is_match(next_state_s);
        end
    end

    // Next-state logic. A failing bit falls back to the longest proper
    // prefix of 101111 that is still a suffix of the received bits: a 0
    // after "101", "1011" or "10111" leaves "10" pending, hence S2.
    // S6 behaves like S0 so no bit of a match is reused.
    always_comb begin
        next_state_s = S0;
        case (state_r)
            S0: begin
                if (bus.x) next_state_s = S1;
                else       next_state_s = S0;
            end
            S1: begin
                if (bus.x) next_state_s = S1;
                else       next_state_s = S2;
            end
            S2: begin
                if (bus.x) next_state_s = S3;
                else       next_state_s = S0;
            end
            S3: begin
                if (bus.x) next_state_s = S4;
                else       next_state_s = S2;
            end
            S4: begin
                if (bus.x) next_state_s = S5;
                else       next_state_s = S2;
            end
            S5: begin
                if (bus.x) next_state_s = S6;
                else       next_state_s = S2;
            end
            S6: begin
                if (bus.x) next_state_s = S1;
                else       next_state_s = S0;
            end
            // Unused encoding 3'd7 recovers to idle on the next edge.
            default: begin
                next_state_s = S0;
            end
        endcase
    end

    assign bus.z = z_r;

endmodule

// File: tb/tb_moore_non_overlap_101111.sv
// ---------------------------------------------------------------------------
// tb_moore_non_overlap_101111
// Directed-vector bench for the 101111 detector. Each vector carries the bit
// stream and a hand-computed string of expected z values, one per bit (z
// observed just after the edge that samples that bit). The driver pushes the
// expected value when it issues a bit; a separate monitor pops and compares
// after every rising edge.
// ---------------------------------------------------------------------------
module tb_moore_non_overlap_101111;

    logic clk;
    logic rst;

    moore_non_overlap_101111_if bus_if ();

    moore_non_overlap_101111 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_q[$];
    string tag_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare z against the oldest outstanding expectation.
    initial begin
        logic  e;
        string t;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                n_checks++;
                if (bus_if.z !== e) begin
                    n_fail++;
                    $display("FAIL %s: z actual %b required %b at %0t", t, bus_if.z, e, $time);
                end
            end
        end
    end

    task automatic check_z0(input string name);
        n_checks++;
        if (bus_if.z !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: z actual %b required 0 at %0t", name, bus_if.z, $time);
        end
    endtask

    // Hold reset for two cycles with x toggling; z must stay low.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_z0("reset_enter");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            bus_if.x = ~bus_if.x;
            @(posedge clk);
            #1;
            check_z0("reset_hold");
        end
        @(negedge clk);
        rst = 1'b1;
        bus_if.x = 1'b0;
    endtask

    // Issue one bit per cycle and push the matching expected z.
    task automatic send_vec(input string name, input string bits, input string expz);
        if (bits.len() != expz.len()) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: vector length %0d required %0d", name, expz.len(), bits.len());
        end
        for (int i = 0; i < bits.len(); i++) begin
            @(negedge clk);
            bus_if.x = (bits[i] == "1") ? 1'b1 : 1'b0;
            exp_q.push_back((expz[i] == "1") ? 1'b1 : 1'b0);
            tag_q.push_back(name);
        end
    endtask

    // Wait (bounded) until the monitor has consumed every expectation.
    task automatic drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 50) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: pending expectations actual %0d required 0", name, exp_q.size());
            exp_q.delete();
            tag_q.delete();
        end
    endtask

    initial begin
        rst      = 1'b0;
        bus_if.x = 1'b0;

        do_reset();
        send_vec("basic_stream", "11011110010111101111", "00000010000000100000");
        drain("basic_stream");

        do_reset();
        send_vec("non_overlap", "10111101111", "00000100000");
        drain("non_overlap");

        do_reset();
        send_vec("back_to_back", "101111101111", "000001000001");
        drain("back_to_back");

        do_reset();
        send_vec("fallback_s3", "10101111", "00000001");
        drain("fallback_s3");

        do_reset();
        send_vec("fallback_s5", "1011101111", "0000000001");
        drain("fallback_s5");

        do_reset();
        send_vec("near_zeros", "00000000000000000000", "00000000000000000000");
        send_vec("near_ones",  "11111111111111111111", "00000000000000000000");
        drain("near_ones");
        do_reset();
        send_vec("near_1011101110", "10111011101011101110", "00000000000000000000");
        drain("near_1011101110");

        // Async reset while in S6: z must fall without a clock edge.
        do_reset();
        send_vec("s6_reach", "101111", "000001");
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_z0("async_reset_s6");
        exp_q.delete();
        tag_q.delete();
        @(posedge clk);
        #1;
        check_z0("async_reset_hold");
        @(negedge clk);
        rst = 1'b1;
        bus_if.x = 1'b0;
        // Prefix lost: only a complete pattern after reset may fire.
        send_vec("after_abort", "1111101111", "0000000001");
        drain("after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
